// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cmd_sequencer
// Brief    : Round-robin merge of two command requesters into a FIFO that is
//            drained into LCD_CTRL one command at a time, gated by busy/done.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [3:0]       req0_cmd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_cmd,
  output logic             req1_ready,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output logic [3:0]       cmd,
  output logic             cmd_valid,
  output logic             finished,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int               c_PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0] c_DEPTH     = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W:0] c_PTR_ONE   = (c_PTR_W + 1)'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       c_CMD_WRITE = 4'd0;
  localparam logic [3:0]       c_CMD_MAX   = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_DONE    = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         mem_q [FIFO_DEPTH];
  logic [c_PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic               rr_q, rr_d;
  logic               wr_queued_q, wr_queued_d;
  logic               last_wr_q, last_wr_d;
  logic               wait_q, wait_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [c_PTR_W:0]   w_count;
  logic               w_full, w_empty, w_pop, w_allow;
  logic               w_gnt0, w_gnt1, w_acc, w_push;
  logic [3:0]         w_code;
  logic               w_start, w_complete;

  assign w_count = wr_ptr_q - rd_ptr_q;
  assign w_full  = (w_count == c_DEPTH);
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_pop   = (state_q == S_ISSUE);
  // The head leaving in ISSUE was already captured into cmd_q, so its slot may be refilled.
  assign w_allow = (!w_full || w_pop) && !wr_queued_q && (state_q != S_FIN);

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_allow) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = ~rr_q;
        w_gnt1 = rr_q;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign w_acc  = w_gnt0 | w_gnt1;
  assign w_code = w_gnt1 ? req1_cmd : req0_cmd;
  assign w_push = w_acc && (w_code <= c_CMD_MAX);

  always_comb begin
    rr_d        = rr_q;
    wr_queued_d = wr_queued_q;
    drop_d      = drop_q;
    if (w_acc && req0_valid && req1_valid) rr_d = w_gnt0;
    if (w_push && (w_code == c_CMD_WRITE)) wr_queued_d = 1'b1;
    if (w_acc && !w_push && (drop_q != '1)) drop_d = drop_q + c_CNT_ONE;
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    last_wr_d  = last_wr_q;
    wait_d     = wait_q;
    issued_d   = issued_q;
    w_start    = 1'b0;
    w_complete = 1'b0;
    case (state_q)
      S_IDLE:    if (!w_empty && !lcd_busy) w_start = 1'b1;
      S_ISSUE: begin
        state_d = S_WAIT_HI;
        wait_d  = 1'b0;
        if (issued_q != '1) issued_d = issued_q + c_CNT_ONE;
      end
      S_WAIT_HI: begin
        if (lcd_busy)    state_d    = S_WAIT_LO;
        else if (wait_q) w_complete = 1'b1;
        else             wait_d     = 1'b1;
      end
      S_WAIT_LO: if (!lcd_busy) w_complete = 1'b1;
      S_DONE:    if (lcd_done) state_d = S_FIN;
      S_FIN:     state_d = S_FIN;
      default:   state_d = S_IDLE;
    endcase
    // Completion chains straight into the next ISSUE to keep the 3-cycle spacing.
    if (w_complete) begin
      if (last_wr_q)     state_d = S_DONE;
      else if (!w_empty) w_start = 1'b1;
      else               state_d = S_IDLE;
    end
    if (w_start) begin
      state_d   = S_ISSUE;
      cmd_d     = mem_q[rd_ptr_q[c_PTR_W-1:0]];
      last_wr_d = (mem_q[rd_ptr_q[c_PTR_W-1:0]] == c_CMD_WRITE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rr_q        <= 1'b0;
      wr_queued_q <= 1'b0;
      last_wr_q   <= 1'b0;
      wait_q      <= 1'b0;
      cmd_q       <= '0;
      issued_q    <= '0;
      drop_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      wr_queued_q <= wr_queued_d;
      last_wr_q   <= last_wr_d;
      wait_q      <= wait_d;
      cmd_q       <= cmd_d;
      issued_q    <= issued_d;
      drop_q      <= drop_d;
      if (w_push) begin
        mem_q[wr_ptr_q[c_PTR_W-1:0]] <= w_code;
        wr_ptr_q                     <= wr_ptr_q + c_PTR_ONE;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign cmd        = cmd_q;
  assign cmd_valid  = (state_q == S_ISSUE);
  assign finished   = (state_q == S_FIN);
  assign issued_cnt = issued_q;
  assign drop_cnt   = drop_q;

endmodule
`default_nettype wire
